// File: rtl/clk_div_pkg.sv
// Shared types for the multi-channel clock divider: output mode encoding and
// the per-channel configuration record.
package clk_div_pkg;

    localparam int CNT_W = 22;

    typedef enum logic {
        DIV_TICK   = 1'b0,
        DIV_SQUARE = 1'b1
    } div_mode_e;

    typedef struct packed {
        logic [CNT_W-1:0] div;
        div_mode_e        mode;
        logic             en;
    } div_cfg_t;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/shadow configuration, pending flag and
// registered tick/square outputs. Shadow config lands only at terminal count or sync.
module clk_div_chan #(
    parameter int               CNT_W       = 22,
    parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(22'd49999),
    parameter logic             EN_AT_RESET = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sync,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    input  logic             wr_mode,
    input  logic             wr_en,
    output logic             tick,
    output logic             clk_out,
    output logic             pending
);
    import clk_div_pkg::*;

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] div_r;
    logic [CNT_W-1:0] sdiv_r;
    div_mode_e        mode_r;
    div_mode_e        smode_r;
    logic             en_r;
    logic             sen_r;
    logic             pend_r;
    logic             tick_r;
    logic             clk_r;

    logic             term_s;
    div_mode_e        wr_mode_s;
    div_mode_e        nxt_mode_s;
    logic             nxt_en_s;

    assign wr_mode_s = div_mode_e'(wr_mode);
    assign term_s    = (cnt_r == div_r);

    // Configuration that will be in force after a terminal count
    always_comb begin
        nxt_mode_s = pend_r ? smode_r : mode_r;
        nxt_en_s   = pend_r ? sen_r   : en_r;
    end

    // Counter, configuration registers and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r   <= '0;
            div_r   <= DEFAULT_DIV;
            sdiv_r  <= DEFAULT_DIV;
            mode_r  <= DIV_SQUARE;
            smode_r <= DIV_SQUARE;
            en_r    <= EN_AT_RESET;
            sen_r   <= EN_AT_RESET;
            pend_r  <= 1'b0;
            tick_r  <= 1'b0;
            clk_r   <= 1'b0;
        end else if (!en_r) begin
            // Idle channel: writes take effect at once, counting restarts from 0
            cnt_r  <= '0;
            tick_r <= 1'b0;
            clk_r  <= 1'b0;
            pend_r <= 1'b0;
            if (wr) begin
                div_r  <= wr_div;
                mode_r <= wr_mode_s;
                en_r   <= wr_en;
            end else begin
                div_r  <= div_r;
            end
        end else if (sync) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
            clk_r  <= 1'b0;
            if (pend_r) begin
                div_r  <= sdiv_r;
                mode_r <= smode_r;
                en_r   <= sen_r;
            end else begin
                div_r  <= div_r;
            end
            pend_r <= wr;
            if (wr) begin
                sdiv_r  <= wr_div;
                smode_r <= wr_mode_s;
                sen_r   <= wr_en;
            end else begin
                sdiv_r  <= sdiv_r;
            end
        end else begin
            tick_r <= term_s;
            if (term_s) begin
                cnt_r <= '0;
                clk_r <= (nxt_en_s && (nxt_mode_s == DIV_SQUARE)) ? ~clk_r : 1'b0;
                if (pend_r) begin
                    div_r  <= sdiv_r;
                    mode_r <= smode_r;
                    en_r   <= sen_r;
                end else begin
                    div_r  <= div_r;
                end
            end else begin
                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                clk_r <= (mode_r == DIV_SQUARE) ? clk_r : 1'b0;
            end
            // A write coinciding with terminal count waits for the following one
            pend_r <= wr | (pend_r & ~term_s);
            if (wr) begin
                sdiv_r  <= wr_div;
                smode_r <= wr_mode_s;
                sen_r   <= wr_en;
            end else begin
                sdiv_r  <= sdiv_r;
            end
        end
    end

    assign tick    = tick_r;
    assign clk_out = clk_r;
    assign pending = pend_r;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable tick/clock generator: config decode and handshake
// around NUM_CH independent clk_div_chan instances.
module clk_div_multi #(
    parameter int               NUM_CH      = 4,
    parameter int               CNT_W       = 22,
    parameter logic [CNT_W-1:0] DEFAULT_DIV = 22'd49999,
    parameter logic             EN_AT_RESET = 1'b1,
    localparam int              CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic              cfg_mode,
    input  logic              cfg_en,
    input  logic              sync,
    output logic [NUM_CH-1:0] ch_tick,
    output logic [NUM_CH-1:0] ch_clk,
    output logic [NUM_CH-1:0] ch_pending
);
    import clk_div_pkg::*;

    logic              pend_sel_s;
    logic              accept_s;
    logic [NUM_CH-1:0] wr_s;

    // Pending flag of the addressed channel; out-of-range indices select nothing
    always_comb begin
        pend_sel_s = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            pend_sel_s = pend_sel_s | (ch_pending[i] & (cfg_ch == CH_W'(i)));
        end
    end

    assign cfg_ready = rst_n & ~pend_sel_s;
    assign accept_s  = cfg_valid & cfg_ready;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign wr_s[g] = accept_s & (cfg_ch == CH_W'(g));

        clk_div_chan #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV),
            .EN_AT_RESET (EN_AT_RESET)
        ) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .sync    (sync),
            .wr      (wr_s[g]),
            .wr_div  (cfg_div),
            .wr_mode (cfg_mode),
            .wr_en   (cfg_en),
            .tick    (ch_tick[g]),
            .clk_out (ch_clk[g]),
            .pending (ch_pending[g])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Randomised scoreboard bench for clk_div_multi against a time-based reference model.
module tb_clk_div_multi;
    localparam int N   = 4;
    localparam int DEF = 49999;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [1:0]    cfg_ch;
    logic [21:0]   cfg_div;
    logic          cfg_mode;
    logic          cfg_en;
    logic          sync;
    logic [N-1:0]  ch_tick;
    logic [N-1:0]  ch_clk;
    logic [N-1:0]  ch_pending;

    clk_div_multi #(
        .NUM_CH      (N),
        .CNT_W       (22),
        .DEFAULT_DIV (22'd49999),
        .EN_AT_RESET (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_div    (cfg_div),
        .cfg_mode   (cfg_mode),
        .cfg_en     (cfg_en),
        .sync       (sync),
        .ch_tick    (ch_tick),
        .ch_clk     (ch_clk),
        .ch_pending (ch_pending)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] tick;
        logic [N-1:0] clk;
        logic [N-1:0] pend;
    } exp_t;

    exp_t   q[$];
    int     checks = 0;
    int     errors = 0;
    bit     started = 1'b0;
    bit     m_acc = 1'b0;

    // Reference model: a channel ticks when (D+1) edges have elapsed since its last restart
    longint k = 0;
    longint m_start[N];
    int     m_div[N], m_sdiv[N];
    bit     m_mode[N], m_smode[N], m_en[N], m_sen[N], m_pend[N], m_clk[N];

    function automatic void apply_shadow(input int i);
        m_div[i]  = m_sdiv[i];
        m_mode[i] = m_smode[i];
        m_en[i]   = m_sen[i];
        m_pend[i] = 1'b0;
    endfunction

    function automatic void latch_shadow(input int i);
        m_sdiv[i]  = int'(cfg_div);
        m_smode[i] = cfg_mode;
        m_sen[i]   = cfg_en;
        m_pend[i]  = 1'b1;
    endfunction

    always @(posedge clk) begin
        exp_t     e;
        bit [N-1:0] acc;
        k = k + 1;
        e = '0;
        for (int i = 0; i < N; i++)
            acc[i] = cfg_valid && rst_n && !m_pend[i] && (int'(cfg_ch) == i);
        for (int i = 0; i < N; i++) begin
            if (!rst_n) begin
                m_div[i] = DEF; m_sdiv[i] = DEF;
                m_mode[i] = 1'b1; m_smode[i] = 1'b1;
                m_en[i] = 1'b1; m_sen[i] = 1'b1;
                m_pend[i] = 1'b0; m_clk[i] = 1'b0; m_start[i] = k;
            end else if (!m_en[i]) begin
                m_clk[i] = 1'b0;
                if (acc[i]) begin
                    m_div[i] = int'(cfg_div); m_mode[i] = cfg_mode; m_en[i] = cfg_en;
                    m_start[i] = k;
                end
            end else if (sync) begin
                m_clk[i] = 1'b0;
                m_start[i] = k;
                if (m_pend[i]) apply_shadow(i);
                if (acc[i]) latch_shadow(i);
            end else begin
                if ((k - m_start[i]) == longint'(m_div[i]) + 1) begin
                    e.tick[i] = 1'b1;
                    m_start[i] = k;
                    if (m_pend[i]) apply_shadow(i);
                    m_clk[i] = (m_en[i] && m_mode[i]) ? !m_clk[i] : 1'b0;
                end else if (!m_mode[i]) begin
                    m_clk[i] = 1'b0;
                end
                if (acc[i]) latch_shadow(i);
            end
            e.clk[i]  = m_clk[i];
            e.pend[i] = m_pend[i];
        end
        q.push_back(e);
        m_acc   = |acc;
        started = 1'b1;
    end

    // Monitor: pop the expected post-edge state and compare on the falling edge
    always @(negedge clk) begin
        exp_t e;
        bit   exp_ready;
        if (started) begin
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL scoreboard_empty at cycle %0d: no expected entry", k);
            end else begin
                e = q.pop_front();
                checks++;
                if (ch_tick !== e.tick) begin
                    errors++;
                    $display("FAIL ch_tick cycle %0d: got %b expected %b", k, ch_tick, e.tick);
                end
                checks++;
                if (ch_clk !== e.clk) begin
                    errors++;
                    $display("FAIL ch_clk cycle %0d: got %b expected %b", k, ch_clk, e.clk);
                end
                checks++;
                if (ch_pending !== e.pend) begin
                    errors++;
                    $display("FAIL ch_pending cycle %0d: got %b expected %b", k, ch_pending, e.pend);
                end
            end
            exp_ready = rst_n && !m_pend[cfg_ch];
            checks++;
            if (cfg_ready !== exp_ready) begin
                errors++;
                $display("FAIL cfg_ready cycle %0d ch %0d: got %b expected %b", k, cfg_ch, cfg_ready, exp_ready);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Hold a write until it is accepted, bounded by a cycle budget
    task automatic write_cfg(input int ch, input int d, input bit mode, input bit en);
        bit done;
        done      = 1'b0;
        cfg_valid = 1'b1;
        cfg_ch    = 2'(ch);
        cfg_div   = 22'(d);
        cfg_mode  = mode;
        cfg_en    = en;
        for (int n = 0; n < 60000 && !done; n++) begin
            step();
            done = m_acc;
        end
        cfg_valid = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL write_timeout ch %0d: accepted 0 expected 1", ch);
        end
    endtask

    task automatic pulse_sync();
        sync = 1'b1;
        step();
        sync = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; cfg_valid = 1'b0; cfg_ch = 2'd0; cfg_div = 22'd0;
        cfg_mode = 1'b0; cfg_en = 1'b0; sync = 1'b0;
        run(3);
        rst_n = 1'b1;
        run(100);
        // Mid-period writes pend until the default terminal count
        write_cfg(1, 3, 1'b1, 1'b1);
        write_cfg(2, 0, 1'b0, 1'b1);
        write_cfg(1, 3, 1'b1, 1'b1);
        run(30);
        write_cfg(3, 5, 1'b1, 1'b1);
        run(40);
        pulse_sync();
        run(60);
        // Disable ch0 through sync, then re-enable immediately with D=9
        write_cfg(0, 7, 1'b1, 1'b0);
        pulse_sync();
        run(20);
        write_cfg(0, 9, 1'b1, 1'b1);
        run(40);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        run(20);
        for (int i = 0; i < 3000; i++) begin
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_ch    = 2'($urandom_range(0, N - 1));
            cfg_div   = 22'($urandom_range(0, 12));
            cfg_mode  = 1'($urandom_range(0, 1));
            cfg_en    = ($urandom_range(0, 7) != 0);
            sync      = ($urandom_range(0, 29) == 0);
            rst_n     = ($urandom_range(0, 999) != 0);
            step();
        end
        cfg_valid = 1'b0; sync = 1'b0; rst_n = 1'b1;
        run(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
